// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative 32-bit multiply/divide datapath: LOAD, 32 RUN steps, FIX, DONE.
// Build option MULTDIV_DIVZERO_EARLY_EN: a divide-by-zero skips RUN/FIX and goes LOAD -> DONE.
module multdiv_ctrl (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       ctrl_mult,
    input  logic       ctrl_div,
    input  logic       div_zero,
    output logic       busy,
    output logic       op_div,
    output logic       dp_load,
    output logic       dp_step,
    output logic       dp_fix,
    output logic [4:0] count,
    output logic       result_rdy,
    output logic       exception
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [4:0] count_tog;
    logic       op_div_q, op_div_d;
    logic       exc_q, exc_d;
    logic       start;

    assign start = ctrl_mult | ctrl_div;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            op_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_div_q <= op_div_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
`ifdef MULTDIV_DIVZERO_EARLY_EN
            LOAD: state_d = exc_q ? DONE : RUN;
`else
            LOAD: state_d = RUN;
`endif
            RUN:  if (count_q == 5'd31) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operation latch plus toggle-chain counter: bit i flips when all lower bits are set.
    always_comb begin
        op_div_d = op_div_q;
        exc_d    = exc_q;
        if (state_q == IDLE && start) begin
            op_div_d = ~ctrl_mult;
            exc_d    = ctrl_div & div_zero & ~ctrl_mult;
        end
        count_tog[0] = (state_q == RUN);
        for (int i = 1; i < 5; i++) begin
            count_tog[i] = count_tog[i-1] & count_q[i-1];
        end
        count_d = (state_q == LOAD) ? 5'd0 : (count_q ^ count_tog);
    end

    always_comb begin
        busy       = (state_q != IDLE);
        op_div     = op_div_q;
        dp_load    = (state_q == LOAD);
        dp_step    = (state_q == RUN);
        dp_fix     = (state_q == FIX);
        count      = count_q;
        result_rdy = (state_q == DONE);
        exception  = (state_q == DONE) & exc_q;
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus random starts and resets,
// compared cycle by cycle against a phase-offset reference model.
module tb_multdiv_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       ctrl_mult, ctrl_div, div_zero;
    logic       busy, op_div, dp_load, dp_step, dp_fix, result_rdy, exception;
    logic [4:0] count;

`ifdef MULTDIV_DIVZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: cycles elapsed since the accepted start (1 = the LOAD cycle).
    bit m_active = 1'b0;
    int m_phase  = 0;
    int m_last   = 35;
    bit m_opdiv  = 1'b0;
    bit m_exc    = 1'b0;
    int obs_steps = 0;

    multdiv_ctrl dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .div_zero   (div_zero),
        .busy       (busy),
        .op_div     (op_div),
        .dp_load    (dp_load),
        .dp_step    (dp_step),
        .dp_fix     (dp_fix),
        .count      (count),
        .result_rdy (result_rdy),
        .exception  (exception)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input bit m, input bit d, input bit z);
        bit was_idle;
        was_idle = !m_active;
        if (m_active) begin
            m_phase++;
            if (m_phase > m_last) m_active = 1'b0;
        end
        if (was_idle && (m || d)) begin
            m_active = 1'b1;
            m_phase  = 1;
            m_opdiv  = !m;
            m_exc    = d && z && !m;
            m_last   = (EARLY && m_exc) ? 2 : 35;
        end
    endtask

    task automatic compareAll();
        bit         skip, e_load, e_step, e_fix, e_rdy, e_exc;
        logic [4:0] e_cnt;
        skip   = EARLY && m_exc;
        e_load = m_active && m_phase == 1;
        e_step = m_active && !skip && m_phase >= 2 && m_phase <= 33;
        e_fix  = m_active && !skip && m_phase == 34;
        e_rdy  = m_active && m_phase == m_last;
        e_exc  = e_rdy && m_exc;
        e_cnt  = e_step ? 5'(m_phase - 2) : 5'd0;
        checkOutput("ctrl", {25'd0, busy, op_div, dp_load, dp_step, dp_fix, result_rdy, exception},
                    {25'd0, m_active, m_opdiv, e_load, e_step, e_fix, e_rdy, e_exc});
        checkOutput("count", {27'd0, count}, {27'd0, e_cnt});
        if (dp_load) obs_steps = 0;
        if (dp_step) obs_steps++;
        if (result_rdy) checkOutput("nsteps", obs_steps, skip ? 0 : 32);
    endtask

    task automatic applyStimulus(input bit m, input bit d, input bit z);
        ctrl_mult = m;
        ctrl_div  = d;
        div_zero  = z;
        @(posedge clk);
        modelEdge(m, d, z);
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        div_zero  = 1'b0;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic applyReset();
        #2 clr_n = 1'b0;
        #1;
        checkOutput("rst_ctrl", {25'd0, busy, op_div, dp_load, dp_step, dp_fix, result_rdy, exception}, 32'd0);
        checkOutput("rst_count", {27'd0, count}, 32'd0);
        m_active  = 1'b0;
        m_opdiv   = 1'b0;
        m_exc     = 1'b0;
        obs_steps = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            compareAll();
        end
        #2 clr_n = 1'b1;
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        int r;
        clr_n     = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        div_zero  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compareAll();
        #2 clr_n = 1'b1;
        @(negedge clk);

        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(37);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(37);
        applyStimulus(1'b0, 1'b1, 1'b1);
        idleCycles(37);

        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        idleCycles(30);

        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(34);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idleCycles(37);

        applyStimulus(1'b1, 1'b1, 1'b1);
        idleCycles(37);

        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(18);
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(37);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 399) == 0) begin
                applyReset();
            end else begin
                applyStimulus(r == 0 || r == 3, r == 1 || r == 2 || r == 3, 1'($urandom_range(0, 1)));
            end
        end
        idleCycles(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the iterative 32-bit multiply/divide unit. It accepts a single-cycle multiply or divide start and steps the shared shift/add datapath through load, 32 iterations, a final sign-fix, and a one-cycle result-ready pulse. An internal 5-bit iteration counter provides the step count. Divide-by-zero is reported as an exception alongside the ready pulse. The block sits between the processor's multdiv issue logic and the multiplier/divider datapath registers.

## Interface
- No parameters. The iteration count is fixed at 32, i.e. the 5-bit counter wraps 31 -> 0.
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- ctrl_mult  in  1  start multiply; single-cycle pulse
- ctrl_div  in  1  start divide; single-cycle pulse
- div_zero  in  1  divisor operand is zero; valid in the same cycle as ctrl_div
- busy  out  1  operation in progress (any state other than IDLE)
- op_div  out  1  latched operation type (1 = divide); held until the next accepted start
- dp_load  out  1  datapath loads operands and clears the accumulator
- dp_step  out  1  datapath performs one shift/add (mult) or shift/subtract/restore (div) iteration
- dp_fix  out  1  datapath applies final sign correction
- count  out  5  current iteration index
- result_rdy  out  1  result valid; single-cycle pulse
- exception  out  1  divide-by-zero flag; only nonzero while result_rdy=1

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- **IDLE**
  - A start is accepted when ctrl_mult or ctrl_div is high.
  - If both are high, multiply wins: op_div=0 and div_zero is ignored.
  - On an accepted start: latch op_div; latch exc = ctrl_div & div_zero & ~ctrl_mult; go to LOAD.
- **LOAD**: dp_load=1 for one cycle; count cleared to 0; go to RUN.
- **RUN**
  - dp_step=1 every cycle; count increments each cycle.
  - When count==31 and a step is taken, count wraps to 0 and the state goes to FIX.
  - Exactly 32 dp_step cycles per operation.
- **FIX**: dp_fix=1 for one cycle, for both mult and div; go to DONE.
- **DONE**: result_rdy=1 and exception=exc for one cycle; go to IDLE.
- Starts arriving while busy=1 are ignored. No queuing, no abort.
- dp_load, dp_step and dp_fix are mutually exclusive and are 0 in IDLE and DONE.
- Counter: toggle-chain style 5-bit counter, enabled only in RUN, synchronously cleared in LOAD.

## Timing
- Reset values (asynchronous, while clr_n=0): state=IDLE; count=0; op_div=0; exc=0; busy, dp_load, dp_step, dp_fix, result_rdy and exception all 0.
- Reset asserted mid-operation aborts immediately. There is no result_rdy for the aborted operation.
- Start sampled on edge E:
  - LOAD during cycle E+1.
  - RUN during E+2..E+33, with count = 0..31.
  - FIX during E+34.
  - DONE during E+35, so result_rdy is high in cycle E+35.
- Latency is 35 cycles from the start edge to result_rdy.
- A new start may be presented in the cycle after DONE, i.e. in IDLE. A start coincident with DONE is ignored.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Configuration
- MULTDIV_DIVZERO_EARLY_EN
  - Defined: an accepted divide with exc=1 goes LOAD -> DONE. There are no RUN or FIX cycles, dp_step never asserts, and result_rdy + exception=1 occur in cycle E+2.
  - Undefined: divide-by-zero runs the full 35-cycle sequence and flags exception=1 with result_rdy at E+35. Datapath result contents are don't-care.
- Multiply timing is identical in both builds.

## Test plan
- Multiply: ctrl_mult pulse at edge 10 -> dp_load in cycle 11; dp_step in cycles 12..43 (32 pulses, count 0..31); dp_fix in 44; result_rdy=1, exception=0 in 45; busy=0 in 46.
- Divide, nonzero divisor: ctrl_div pulse, div_zero=0 -> same 35-cycle profile, op_div=1, exception=0.
- Divide by zero: ctrl_div with div_zero=1.
  - Macro defined: result_rdy=1, exception=1 at E+2, zero dp_step pulses.
  - Macro undefined: result_rdy=1, exception=1 at E+35.
- Start while busy, then simultaneous starts:
  - ctrl_div pulse during RUN of a multiply -> ignored; single result_rdy at E+35 with op_div=0.
  - ctrl_mult and ctrl_div together with div_zero=1 -> multiply, exception=0.
- Reset mid-operation: clr_n low in cycle E+20 -> all outputs 0 and count=0 immediately. No result_rdy. After release, a new ctrl_mult completes normally in 35 cycles.
